m_store_unit: RTL
=================

# m_store_unit

Memory-stage store unit of the pipelined MIPS core: the narrowing counterpart of the immediate/load extenders. It takes a 32-bit register value plus a store type, steers the sub-word into the correct byte lanes, generates byte enables, flags misaligned stores (AdES), and holds the resulting write in a one-entry buffer with a valid/ready handshake toward the data-memory bridge. It stalls the pipeline while the buffer cannot drain.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `M_StoreReq` in 1: M stage presents a store this cycle.
- `M_StoreOp` in 2: 00 SW, 01 SH, 10 SB, 11 reserved.
- `M_Addr` in 32: effective byte address.
- `M_RtData` in 32: source register value.
- `M_Flush` in 1: CP0 exception/eret flush; kills the incoming request only.
- `M_Stall` out 1: freeze the pipeline from M stage backwards.
- `M_AdES` out 1: combinational store address error for the current request.
- `o_req_valid` out 1: buffered write is pending.
- `o_req_ready` in 1: bridge accepts the write this cycle.
- `o_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `o_wdata` out 32: lane-replicated write data.
- `o_byteen` out 4: byte enables, bit i covers `wdata[8i+7:8i]`.

## Operation
- Alignment check, combinational: `M_AdES = M_StoreReq & (op==11 | (SW & addr[1:0]!=0) | (SH & addr[0]))`.
- Lane steering:
  - SW: `byteen=1111`, `wdata=rt`.
  - SH: `byteen = addr[1] ? 1100 : 0011`, `wdata={rt[15:0],rt[15:0]}`.
  - SB: `byteen = 0001<<addr[1:0]`, `wdata={4{rt[7:0]}}`.
- FSM with states EMPTY and FULL.
  - EMPTY: on `accept` go to FULL and latch addr/wdata/byteen.
  - FULL: if `o_req_ready` and `accept`, reload the buffer and stay FULL. If `o_req_ready` and no accept, go to EMPTY. If not `o_req_ready`, hold.
- `accept = M_StoreReq & ~M_AdES & ~M_Flush & ~M_Stall`.
- `o_req_valid` = (state == FULL).
- `M_Stall = M_StoreReq & FULL & ~o_req_ready`. A store that finds the buffer draining this cycle is accepted without a stall.
- While stalled, the pipeline holds `M_StoreReq`, `M_StoreOp`, `M_Addr` and `M_RtData` stable. The unit re-evaluates every cycle.
- Flush handling:
  - `M_Flush` never cancels a buffered write; buffered writes are committed.
  - `M_Flush` with `M_StoreReq` drops the request, and `M_Stall` is forced to 0 that cycle.
- AdES requests are never buffered and never stall. The exception takes priority over the stall.
- Buffered outputs stay stable while `o_req_valid & ~o_req_ready`.

## Timing
- Reset values: state EMPTY; `o_req_valid`, `o_addr`, `o_wdata`, `o_byteen` = 0. `M_Stall` = 0 and `M_AdES` = 0 are valid combinationally in the reset cycle.
- Latency: a request accepted at edge N is presented on `o_req_*` from cycle N+1.
- A transfer completes on the edge where `o_req_valid & o_req_ready`.
- Throughput: one store per cycle with `o_req_ready` tied high.
- Reset mid-transfer: the pending write is discarded and the bridge sees `o_req_valid` fall at the next edge.
- `M_AdES` and `M_Stall` are combinational from inputs and state. There is no path from `o_req_ready` to any registered output in the same cycle.

## Structure
- Shared package `mips_pkg`:
  - StoreOp encodings `ST_SW`, `ST_SH`, `ST_SB`.
  - CP0 exception code `EXC_ADES = 5'd5`.
  - FSM state encoding.
- One combinational sub-module, `m_store_align`: inputs op, addr[1:0], rt; outputs byteen, wdata, ades.
- The top level holds the FSM and the output registers.

## Test plan
- SB at addr `0x0000_3003`, rt `0x1234_56AB`, ready=1 -> next cycle `o_addr=0x3000`, `byteen=1000`, `wdata=0xABABABAB`, no stall.
- SH at `0x0000_1002`, rt `0xFFFF_BEEF` -> `byteen=1100`, `wdata=0xBEEFBEEF`. SH at `0x1001` -> `M_AdES=1`, `o_req_valid` stays 0.
- SW at `0x2000`, then SW at `0x2004` with ready=0 for 3 cycles -> `M_Stall=1` for exactly 3 cycles. The first write holds stable. Each write is delivered once, in order.
- Back-to-back SWs to `0x10/0x14/0x18` with ready=1 -> three consecutive valid cycles, `M_Stall` never asserted.
- Buffer FULL, ready=0, second store arrives with `M_Flush=1` -> `M_Stall=0`, second store dropped, first still delivered when ready rises.
- `reset` asserted while FULL and ready=0 -> next cycle `o_req_valid=0`, `byteen=0000`. No write emitted after ready rises.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: store opcodes, CP0 exception codes
// and the store-buffer FSM state.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } store_op_e;

  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic {
    SB_EMPTY = 1'b0,
    SB_FULL  = 1'b1
  } sbuf_state_e;

endpackage

// File: rtl/m_store_align.sv
// Combinational lane steering for stores: byte enables, lane-replicated
// write data and the misalignment flag for the given op and low address bits.
module m_store_align
  import mips_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rt,
  output logic [3:0]  byteen,
  output logic [31:0] wdata,
  output logic        ades
);

  // Steer the sub-word into its lanes and flag bad alignment / reserved op.
  always_comb begin
    byteen = '0;
    wdata  = rt;
    ades   = 1'b0;
    case (store_op_e'(op))
      ST_SW: begin
        byteen = '1;
        wdata  = rt;
        ades   = (addr_lo != 2'b00);
      end
      ST_SH: begin
        byteen = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{rt[15:0]}};
        ades   = addr_lo[0];
      end
      ST_SB: begin
        byteen = 4'b0001 << addr_lo;
        wdata  = {4{rt[7:0]}};
        ades   = 1'b0;
      end
      default: begin
        byteen = '0;
        wdata  = rt;
        ades   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/m_store_unit.sv
// M-stage store unit: aligns the store, raises AdES, and holds the write in a
// one-entry buffer handshaking with the data-memory bridge.
module m_store_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        M_StoreReq,
  input  logic [1:0]  M_StoreOp,
  input  logic [31:0] M_Addr,
  input  logic [31:0] M_RtData,
  input  logic        M_Flush,
  output logic        M_Stall,
  output logic        M_AdES,
  output logic        o_req_valid,
  input  logic        o_req_ready,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_byteen
);

  sbuf_state_e state, state_next;
  logic [3:0]  al_byteen;
  logic [31:0] al_wdata;
  logic        al_ades;
  logic        full;
  logic        accept;

  m_store_align u_align (
    .op      (M_StoreOp),
    .addr_lo (M_Addr[1:0]),
    .rt      (M_RtData),
    .byteen  (al_byteen),
    .wdata   (al_wdata),
    .ades    (al_ades)
  );

  assign full        = (state == SB_FULL);
  assign o_req_valid = full;
  assign M_AdES      = M_StoreReq & al_ades;
  // Exception and flush both suppress the stall; a draining buffer never stalls.
  assign M_Stall     = M_StoreReq & ~M_AdES & ~M_Flush & full & ~o_req_ready;
  assign accept      = M_StoreReq & ~M_AdES & ~M_Flush & ~M_Stall;

  // Buffer occupancy: fill on accept, drain on ready, reload when both happen.
  always_comb begin
    state_next = state;
    case (state)
      SB_EMPTY: if (accept) state_next = SB_FULL;
      SB_FULL:  if (o_req_ready) state_next = accept ? SB_FULL : SB_EMPTY;
      default:  state_next = SB_EMPTY;
    endcase
  end

  // State and buffered write registers; payload only changes on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SB_EMPTY;
      o_addr   <= '0;
      o_wdata  <= '0;
      o_byteen <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        o_addr   <= {M_Addr[31:2], 2'b00};
        o_wdata  <= al_wdata;
        o_byteen <= al_byteen;
      end
    end
  end

endmodule
